// File: rtl/cap_conditioner_if.sv
// Bus bundle for the crank-capture conditioner: raw input and limits in, clean level and tooth qualification out.
interface cap_conditioner_if #(
  parameter int FILT_W = 8,
  parameter int PER_W  = 24
);
  logic              cap_in;
  logic              edge_sel;
  logic [FILT_W-1:0] filt_len;
  logic [PER_W-1:0]  min_per;
  logic [PER_W-1:0]  max_per;
  logic              cap_out;
  logic              tooth_stb;
  logic [PER_W-1:0]  tooth_per;
  logic              err_short;
  logic              err_long;
  logic              sync_ok;
  logic              gap_stb;

  modport master (
    output cap_in, edge_sel, filt_len, min_per, max_per,
    input  cap_out, tooth_stb, tooth_per, err_short, err_long, sync_ok, gap_stb
  );

  modport slave (
    input  cap_in, edge_sel, filt_len, min_per, max_per,
    output cap_out, tooth_stb, tooth_per, err_short, err_long, sync_ok, gap_stb
  );
endinterface

// File: rtl/cap_conditioner.sv
// Crank-capture conditioner: synchroniser, glitch filter, active-edge select and tooth period qualification.
// Defining CAP_GAP_DETECT_EN adds the missing-tooth gap flag (gap_stb); otherwise gap_stb is tied low.
module cap_conditioner #(
  parameter int FILT_W = 8,
  parameter int PER_W  = 24
) (
  input logic              clk,
  input logic              rst,
  cap_conditioner_if.slave bus
);

  // state  | meaning
  // S_IDLE | no reference edge yet (after reset or stall); next active edge is the reference
  // S_RUN  | synchronised; active edges are qualified against min_per/max_per
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [FILT_W-1:0] FILT_ONE = FILT_W'(1);
  localparam logic [PER_W-1:0]  PER_ONE  = PER_W'(1);

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              cap_s_q, cap_s_d;
  logic [FILT_W-1:0] fcnt_q, fcnt_d;
  logic              cap_out_q, cap_out_d;
  logic              cap_prev_q, cap_prev_d;
  logic [PER_W-1:0]  pcnt_q, pcnt_d;
  logic [PER_W-1:0]  tooth_per_q, tooth_per_d;
  logic              tooth_stb_q, tooth_stb_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic              sync_ok_q, sync_ok_d;
  logic              rise, fall, act_edge;
`ifdef CAP_GAP_DETECT_EN
  logic [PER_W-1:0]  prev_per_q, prev_per_d;
  logic              gap_stb_q, gap_stb_d;
`endif

  always_comb begin
    sync1_d    = bus.cap_in;
    cap_s_d    = sync1_q;
    cap_prev_d = cap_out_q;

    cap_out_d = cap_out_q;
    fcnt_d    = '0;
    if (cap_s_q != cap_out_q) begin
      if (fcnt_q == bus.filt_len) begin
        cap_out_d = ~cap_out_q;
      end else begin
        fcnt_d = fcnt_q + FILT_ONE;
      end
    end

    rise     = cap_out_q & ~cap_prev_q;
    fall     = ~cap_out_q & cap_prev_q;
    act_edge = bus.edge_sel ? rise : fall;

    pcnt_d      = (&pcnt_q) ? pcnt_q : pcnt_q + PER_ONE;
    state_d     = state_q;
    tooth_per_d = tooth_per_q;
    tooth_stb_d = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
`ifdef CAP_GAP_DETECT_EN
    prev_per_d  = prev_per_q;
    gap_stb_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (act_edge) begin
          pcnt_d  = PER_ONE;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (pcnt_q == bus.max_per) begin
          err_long_d = 1'b1;
          state_d    = S_IDLE;
`ifdef CAP_GAP_DETECT_EN
          prev_per_d = '0;
`endif
          // an edge coinciding with the stall becomes the new reference edge
          if (act_edge) begin
            pcnt_d  = PER_ONE;
            state_d = S_RUN;
          end
        end else if (act_edge) begin
          if (pcnt_q < bus.min_per) begin
            err_short_d = 1'b1;
          end else if (pcnt_q < bus.max_per) begin
            tooth_stb_d = 1'b1;
            tooth_per_d = pcnt_q;
            pcnt_d      = PER_ONE;
`ifdef CAP_GAP_DETECT_EN
            // prev_per of zero marks the first tooth after IDLE, which never flags a gap
            gap_stb_d  = (prev_per_q != '0) && ({1'b0, pcnt_q} > {prev_per_q, 1'b0});
            prev_per_d = pcnt_q;
`endif
          end
        end
      end
    endcase

    sync_ok_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      cap_s_q     <= 1'b0;
      fcnt_q      <= '0;
      cap_out_q   <= 1'b0;
      cap_prev_q  <= 1'b0;
      pcnt_q      <= '0;
      tooth_per_q <= '0;
      tooth_stb_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      sync_ok_q   <= 1'b0;
`ifdef CAP_GAP_DETECT_EN
      prev_per_q  <= '0;
      gap_stb_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      cap_s_q     <= cap_s_d;
      fcnt_q      <= fcnt_d;
      cap_out_q   <= cap_out_d;
      cap_prev_q  <= cap_prev_d;
      pcnt_q      <= pcnt_d;
      tooth_per_q <= tooth_per_d;
      tooth_stb_q <= tooth_stb_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      sync_ok_q   <= sync_ok_d;
`ifdef CAP_GAP_DETECT_EN
      prev_per_q  <= prev_per_d;
      gap_stb_q   <= gap_stb_d;
`endif
    end
  end

  assign bus.cap_out   = cap_out_q;
  assign bus.tooth_stb = tooth_stb_q;
  assign bus.tooth_per = tooth_per_q;
  assign bus.err_short = err_short_q;
  assign bus.err_long  = err_long_q;
  assign bus.sync_ok   = sync_ok_q;
`ifdef CAP_GAP_DETECT_EN
  assign bus.gap_stb   = gap_stb_q;
`else
  assign bus.gap_stb   = 1'b0;
`endif

endmodule

// File: tb/tb_cap_conditioner.sv
// Self-checking bench for cap_conditioner: glitch-filter table, directed tooth sequences and
// randomized tooth trains checked against a timestamp-based reference model.
module tb_cap_conditioner;
  localparam int FW   = 8;
  localparam int PW   = 24;
  localparam int MAXC = 6000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cap_conditioner_if #(.FILT_W(FW), .PER_W(PW)) bus ();
  cap_conditioner #(.FILT_W(FW), .PER_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int flen;
    int plen;
    bit rise;
    int dly;
  } gvec_t;
  gvec_t gv [8];

  int n_tests = 0;
  int n_fail  = 0;

  bit wave    [MAXC];
  bit edge_at [MAXC];
  bit e_stb   [MAXC];
  bit e_short [MAXC];
  bit e_long  [MAXC];
  bit e_sync  [MAXC];
  bit e_gap   [MAXC];
  int e_per   [MAXC];
  int plan_q[$];

  int o_stb, o_short, o_long, o_gap, o_last_per;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input bit es);
    bus.cap_in = ~es;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.cap_out, bus.tooth_stb, bus.err_short, bus.err_long,
                            bus.sync_ok, bus.gap_stb, bus.tooth_per}, 0);
    rst = 1'b0;
  endtask

  // Active cap_in edges start at plan cycle 30 and are spaced by plan_q; each is seen by the
  // edge logic flen+4 clocks later. Stops early (at #1 after that edge) when stop_at is non-zero.
  task automatic run_plan(input int flen, input bit es, input int mn, input int mx,
                          input int stop_at, input bit rnd_hold);
    int a, n, nlast, w_ref, per, p;
    bit run;
`ifdef CAP_GAP_DETECT_EN
    int prev;
`endif
    for (int c = 0; c < MAXC; c++) begin
      wave[c]    = ~es;
      edge_at[c] = 1'b0;
    end
    a     = 30;
    nlast = 30;
    for (int i = 0; i <= plan_q.size(); i++) begin
      int h;
      if (i < plan_q.size())
        h = rnd_hold ? int'($urandom_range(flen + 2, plan_q[i] - flen - 2)) : plan_q[i] / 2;
      else
        h = 20;
      for (int k = 0; k < h; k++) wave[a + k] = es;
      edge_at[a + 4 + flen] = 1'b1;
      nlast = a;
      if (i < plan_q.size()) a += plan_q[i];
    end
    n = nlast + 4 + flen + mx + 30;
    if (n >= MAXC) n = MAXC - 1;

    run   = 1'b0;
    w_ref = 0;
    per   = 0;
`ifdef CAP_GAP_DETECT_EN
    prev  = 0;
`endif
    for (int w = 1; w <= n; w++) begin
      e_stb[w]   = 1'b0;
      e_short[w] = 1'b0;
      e_long[w]  = 1'b0;
      e_gap[w]   = 1'b0;
      if (run && (w - w_ref == mx)) begin
        e_long[w] = 1'b1;
        run       = 1'b0;
`ifdef CAP_GAP_DETECT_EN
        prev      = 0;
`endif
        if (edge_at[w]) begin
          run   = 1'b1;
          w_ref = w;
        end
      end else if (edge_at[w]) begin
        if (!run) begin
          run   = 1'b1;
          w_ref = w;
        end else begin
          p = w - w_ref;
          if (p < mn) begin
            e_short[w] = 1'b1;
          end else if (p < mx) begin
            e_stb[w] = 1'b1;
            per      = p;
            w_ref    = w;
`ifdef CAP_GAP_DETECT_EN
            e_gap[w] = (prev != 0) && (p > 2 * prev);
            prev     = p;
`endif
          end
        end
      end
      e_per[w]  = per;
      e_sync[w] = run;
    end

    o_stb = 0; o_short = 0; o_long = 0; o_gap = 0; o_last_per = 0;
    bus.filt_len = FW'(flen);
    bus.edge_sel = es;
    bus.min_per  = PW'(mn);
    bus.max_per  = PW'(mx);
    bus.cap_in   = wave[0];
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.tooth_stb !== e_stb[c] || bus.err_short !== e_short[c] || bus.err_long !== e_long[c] ||
          bus.sync_ok !== e_sync[c] || bus.gap_stb !== e_gap[c] || bus.tooth_per !== PW'(e_per[c])) begin
        n_fail++;
        $display("FAIL cycle_check c=%0d: got stb/per/short/long/sync/gap=%b/%0d/%b/%b/%b/%b required %b/%0d/%b/%b/%b/%b",
                 c, bus.tooth_stb, bus.tooth_per, bus.err_short, bus.err_long, bus.sync_ok, bus.gap_stb,
                 e_stb[c], e_per[c], e_short[c], e_long[c], e_sync[c], e_gap[c]);
      end
      if (bus.tooth_stb === 1'b1) begin
        o_stb++;
        o_last_per = int'(bus.tooth_per);
      end
      if (bus.err_short === 1'b1) o_short++;
      if (bus.err_long === 1'b1) o_long++;
      if (bus.gap_stb === 1'b1) o_gap++;
      if (c == stop_at) break;
      bus.cap_in = wave[c];
    end
  endtask

  initial begin
    int seen, dly, exp_gap;
    gv[0] = '{3, 3, 1'b0, 0};
    gv[1] = '{3, 5, 1'b1, 6};
    gv[2] = '{3, 4, 1'b1, 6};
    gv[3] = '{0, 1, 1'b1, 3};
    gv[4] = '{1, 1, 1'b0, 0};
    gv[5] = '{1, 2, 1'b1, 4};
    gv[6] = '{5, 5, 1'b0, 0};
    gv[7] = '{5, 6, 1'b1, 8};

    bus.cap_in   = 1'b0;
    bus.edge_sel = 1'b1;
    bus.filt_len = '0;
    bus.min_per  = PW'(50);
    bus.max_per  = PW'(1000);

    // glitch filter table
    do_reset(1'b1);
    for (int v = 0; v < 8; v++) begin
      bus.filt_len = FW'(gv[v].flen);
      seen = 0;
      dly  = 0;
      for (int k = 0; k < 40; k++) begin
        if (seen == 0 && bus.cap_out === 1'b1) begin
          seen = 1;
          dly  = k;
        end
        bus.cap_in = (k < gv[v].plen);
        @(posedge clk);
        #1;
      end
      check($sformatf("glitch_rise[%0d]", v), seen, gv[v].rise);
      if (gv[v].rise) check($sformatf("glitch_delay[%0d]", v), dly, gv[v].dly);
      check($sformatf("glitch_settle[%0d]", v), bus.cap_out, 0);
    end

    // nominal teeth
    do_reset(1'b1);
    plan_q = '{100, 100, 100, 100};
    run_plan(0, 1'b1, 50, 1000, 0, 1'b0);
    check("nominal_stb", o_stb, 4);
    check("nominal_per", o_last_per, 100);
    check("nominal_short", o_short, 0);
    check("nominal_long", o_long, 1);

    // falling edge active
    do_reset(1'b0);
    plan_q = '{100, 100};
    run_plan(2, 1'b0, 50, 1000, 0, 1'b0);
    check("falling_stb", o_stb, 2);
    check("falling_per", o_last_per, 100);

    // short tooth
    do_reset(1'b1);
    plan_q = '{20, 80, 100};
    run_plan(0, 1'b1, 50, 1000, 0, 1'b0);
    check("short_stb", o_stb, 2);
    check("short_err", o_short, 1);
    check("short_per", o_last_per, 100);

    // stall then resync
    do_reset(1'b1);
    plan_q = '{100, 1100, 100};
    run_plan(0, 1'b1, 50, 1000, 0, 1'b0);
    check("stall_stb", o_stb, 2);
    check("stall_long", o_long, 2);
    check("stall_per", o_last_per, 100);

    // window boundaries: exactly min accepted, min-1 short, max-1 accepted, max stalls
    do_reset(1'b1);
    plan_q = '{100, 50, 49, 150, 199, 200};
    run_plan(0, 1'b1, 50, 200, 0, 1'b0);
    check("bound_stb", o_stb, 4);
    check("bound_short", o_short, 1);
    check("bound_long", o_long, 2);

    // missing-tooth gap
`ifdef CAP_GAP_DETECT_EN
    exp_gap = 1;
`else
    exp_gap = 0;
`endif
    do_reset(1'b1);
    plan_q = '{100, 100, 300};
    run_plan(0, 1'b1, 50, 1000, 0, 1'b0);
    check("gap_stb_count", o_gap, exp_gap);
    check("gap_last_per", o_last_per, 300);

    // reset 50 clocks into a period (third edge seen at cycle 234)
    do_reset(1'b1);
    plan_q = '{100, 100, 100};
    run_plan(0, 1'b1, 50, 1000, 284, 1'b0);
    check("midrst_pre_stb", o_stb, 2);
    #2;
    rst = 1'b1;
    bus.cap_in = 1'b0;
    #1;
    check("midrst_cap_out", bus.cap_out, 0);
    check("midrst_tooth_stb", bus.tooth_stb, 0);
    check("midrst_tooth_per", bus.tooth_per, 0);
    check("midrst_err_short", bus.err_short, 0);
    check("midrst_err_long", bus.err_long, 0);
    check("midrst_sync_ok", bus.sync_ok, 0);
    check("midrst_gap_stb", bus.gap_stb, 0);
    do_reset(1'b1);
    plan_q = '{100};
    run_plan(0, 1'b1, 50, 1000, 0, 1'b0);
    check("midrst_post_stb", o_stb, 1);
    check("midrst_post_per", o_last_per, 100);

    // randomized tooth trains
    for (int r = 0; r < 6; r++) begin
      int fl, mn, mx, typ, iv;
      bit es, inv;
      fl  = int'($urandom_range(0, 4));
      es  = 1'($urandom_range(0, 1));
      mn  = int'($urandom_range(20, 60));
      inv = ($urandom_range(0, 4) == 0);
      mx  = inv ? int'($urandom_range(15, mn)) : int'($urandom_range(mn + 40, 300));
      plan_q.delete();
      for (int i = 0; i < 8; i++) begin
        typ = int'($urandom_range(0, 5));
        case (typ)
          0:       iv = int'($urandom_range(12, mn - 1));
          1, 2:    iv = inv ? int'($urandom_range(12, mn - 1)) : int'($urandom_range(mn, mx - 1));
          3:       iv = mn;
          4:       iv = mx - 1;
          default: iv = int'($urandom_range(mx, mx + 100));
        endcase
        if (iv < 12) iv = 12;
        plan_q.push_back(iv);
      end
      do_reset(es);
      run_plan(fl, es, mn, mx, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cap_conditioner.md
# cap_conditioner

Crank-capture input conditioner placed directly upstream of `hwag`. Synchronises and glitch-filters the raw VR comparator input, selects the active edge, and measures the clock count between accepted teeth. Rejects teeth closer together than a programmable minimum period and declares loss of sync on a programmable maximum period. Delivers a clean level plus a validated tooth strobe and period word to the angle generator.

## Interface
- `FILT_W`, 8: width of the glitch-filter length and counter.
- `PER_W`, 24: width of the period counter, limits and period output.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cap_in` in 1: raw VR/Hall input, asynchronous to `clk`.
- `edge_sel` in 1: 1 = rising edge is active, 0 = falling edge is active.
- `filt_len` in FILT_W: extra stable clocks required before the filtered level changes.
- `min_per` in PER_W: minimum accepted period in clocks (HWA MIN CAP).
- `max_per` in PER_W: stall limit in clocks (HWA MAX CAP).
- `cap_out` out 1: filtered level.
- `tooth_stb` out 1: one-clock pulse for each accepted tooth.
- `tooth_per` out PER_W: period of the last accepted tooth; holds its value between strobes.
- `err_short` out 1: one-clock pulse when an edge is rejected as too short.
- `err_long` out 1: one-clock pulse when a stall is detected.
- `sync_ok` out 1: high while the state is RUN.
- `gap_stb` out 1: one-clock pulse flagging the missing-tooth gap (see Configuration).

## Operation
- **Synchroniser:** 2-FF synchroniser on `cap_in`, giving `cap_s`.
- **Filter:**
  - `fcnt` counts consecutive clocks with `cap_s != cap_out`.
  - `fcnt` clears on any clock where the two are equal.
  - When `fcnt == filt_len` and they still differ, `cap_out` toggles and `fcnt` clears.
  - With `filt_len=0`, `cap_out` follows `cap_s` with 1 clock of delay.
- **Active edge:** a `cap_out` transition in the direction given by `edge_sel`. `edge_sel` is sampled every clock.
- **Period counter `pcnt`:**
  - Loads 1 in the clock after an accepted or reference edge.
  - Otherwise increments each clock and saturates at all-ones.
  - At an edge, `p = pcnt` equals the number of clocks since the previous accepted edge.
- **State IDLE** (entered on reset and on stall):
  - An active edge is the reference edge: restart `pcnt`, go to RUN.
  - No `tooth_stb` is issued.
- **State RUN:**
  - Active edge with `p < min_per`: pulse `err_short`. The edge is ignored and `pcnt` keeps counting.
  - Active edge with `min_per <= p < max_per`: pulse `tooth_stb`, load `tooth_per = p`, restart `pcnt`.
  - `pcnt == max_per` with no accepted edge: pulse `err_long`, go to IDLE.
  - If an active edge arrives in that same clock, it is taken as the IDLE reference edge: `pcnt` restarts, the state stays in RUN, and only `err_long` pulses.
- **Limits:** `min_per` and `max_per` are live inputs, compared unsigned. If `min_per >= max_per`, no tooth is ever accepted; each short edge gives `err_short` until the stall fires.
- **Reset values:** `cap_out`, `tooth_stb`, `err_short`, `err_long`, `gap_stb` and `sync_ok` are 0; `tooth_per` is 0; all counters are 0; state is IDLE. Reset asserted mid-period aborts everything immediately, and no pulse is emitted on release.

## Timing
- `cap_in` to `cap_out`: `filt_len + 3` clocks (2 synchroniser + `filt_len + 1` filter).
- `cap_out` edge to `tooth_stb`/`err_short`: 1 clock. All outputs are registered.
- `tooth_per` and `gap_stb` are valid in the same clock as `tooth_stb`.
- `err_long` asserts in the clock after `pcnt` reaches `max_per`.
- `sync_ok` rises with the first `pcnt` restart after the reference edge and falls with `err_long`.
- Strobes never assert in two consecutive clocks, because the filter minimum hold is 1 clock plus the edge logic.

## Configuration
- **`CAP_GAP_DETECT_EN` defined:**
  - A `prev_per` register (PER_W) is loaded with every accepted `p`.
  - `gap_stb` pulses together with `tooth_stb` when `p > 2*prev_per`, compared in PER_W+1 bits.
  - The first accepted tooth after IDLE never flags a gap; `prev_per` is cleared on entry to IDLE.
- **Not defined:** `gap_stb` is tied to 0 and `prev_per` is absent.

## Test plan
- **Glitch filter:** `filt_len=3`, `cap_in` high pulse of 3 clocks → `cap_out` stays 0. A 5-clock pulse → `cap_out` rises 6 clocks after `cap_in`.
- **Nominal teeth:** `min_per=50`, `max_per=1000`, `edge_sel=1`, rising edges every 100 clocks.
  - First edge: no strobe.
  - Every later edge: `tooth_stb` with `tooth_per=100`, `sync_ok=1`.
- **Short tooth:** extra rising edge 20 clocks after an accepted edge → `err_short` pulse. The next edge, 100 clocks after the accepted one, gives `tooth_per=100`.
- **Stall:** input stopped for 1000 clocks → `err_long` pulse and `sync_ok=0`. The next edge gives no strobe; the one 100 clocks later gives `tooth_stb` with `tooth_per=100`.
- **Gap (macro on):** periods 100, 100, 300 → `gap_stb` pulses only with the 300 tooth. With the macro off, `gap_stb` stays 0 for the same stimulus.
- **Reset mid-operation:** assert `rst` 50 clocks into a period → all outputs go to 0 asynchronously. After release, the first edge is a reference edge with no strobe.
